axis_traffic_generator: RTL and testbench

- AXI-Stream source for NoC test harness: injects single-flit packets at a programmable rate to uniformly random destinations.
- Payload format is the one the per-destination checker consumes:
  - upper half of tdata = tick at packet creation;
  - low COUNT_WIDTH bits = per-destination sequence number.
- One instance per router input port; drives the port's AXIS slave.

---
 rtl/axis_traffic_generator_if.sv | 16 +
 rtl/axis_traffic_generator.sv | 112 +++++++++++
 tb/tb_axis_traffic_generator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_traffic_generator_if.sv
// rtl/axis_traffic_generator_if.sv - AXI-Stream channel bundle between the traffic generator and a router port
interface axis_traffic_generator_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TDEST_WIDTH = 2,
  parameter int TID_WIDTH   = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axis_traffic_generator.sv
// rtl/axis_traffic_generator.sv - random-destination single-flit AXI-Stream packet source with rate and count limits
module axis_traffic_generator #(
  parameter int          COUNT_WIDTH = 32,
  parameter int          TID         = 0,
  parameter int          TDATA_WIDTH = 512,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          RATE_WIDTH  = 8,
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  input  logic [RATE_WIDTH:0]                      rate,
  input  logic [COUNT_WIDTH-1:0]                   max_packets,
  input  logic [TDATA_WIDTH/2-1:0]                 ticks,
  output logic [2**TDEST_WIDTH-1:0][COUNT_WIDTH-1:0] sent_packets,
  output logic [COUNT_WIDTH-1:0]                   total_sent,
  output logic                                     done,
  axis_traffic_generator_if.master                 axis_out
);
  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, VALID, DONE} state_t;

  state_t                 state, state_next;
  logic [31:0]            lfsr;
  logic [TDEST_WIDTH-1:0] dest;
  logic                   accept;
  logic                   inject;
  logic                   limit_hit;
  logic                   load;
  logic [COUNT_WIDTH-1:0] in_flight;
  logic [COUNT_WIDTH-1:0] seq;
  logic [TDATA_WIDTH-1:0] packet;

  assign axis_out.tvalid = (state == VALID);
  assign axis_out.tlast  = 1'b1;
  assign axis_out.tid    = TID_WIDTH'(TID);
  assign done            = (state == DONE);

  assign accept    = axis_out.tvalid && axis_out.tready;
  assign dest      = lfsr[31 -: TDEST_WIDTH];
  // The output register counts as in flight until its accept edge has updated total_sent.
  assign in_flight = total_sent + COUNT_WIDTH'(axis_out.tvalid);
  assign limit_hit = (max_packets != '0) && (in_flight >= max_packets);
  assign inject    = enable && !limit_hit && ({1'b0, lfsr[RATE_WIDTH-1:0]} < rate);
  assign seq       = sent_packets[dest] + COUNT_WIDTH'(accept && (axis_out.tdest == dest));

  always_comb begin
    packet = '0;
    packet[TDATA_WIDTH-1 -: TDATA_WIDTH/2] = ticks;
    packet[COUNT_WIDTH-1:0] = seq;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (limit_hit) begin
          state_next = DONE;
        end else if (inject) begin
          load       = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (accept) begin
          if (inject) begin
            load = 1'b1;
          end else if (limit_hit) begin
            state_next = DONE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= LFSR_INIT;
    end else begin
      state <= state_next;
      lfsr  <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axis_out.tdata <= '0;
      axis_out.tdest <= '0;
      sent_packets   <= '0;
      total_sent     <= '0;
    end else begin
      if (load) begin
        axis_out.tdata <= packet;
        axis_out.tdest <= dest;
      end
      if (accept) begin
        sent_packets[axis_out.tdest] <= sent_packets[axis_out.tdest] + COUNT_WIDTH'(1);
        total_sent                   <= total_sent + COUNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_axis_traffic_generator.sv
// tb/tb_axis_traffic_generator.sv - directed self-checking bench for axis_traffic_generator
module tb_axis_traffic_generator;
  localparam int CW  = 32;
  localparam int TDW = 64;
  localparam int DW  = 2;
  localparam int IW  = 2;
  localparam int RW  = 8;
  localparam int ND  = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b0;
  logic [RW:0]              rate = '0;
  logic [CW-1:0]            max_packets = '0;
  logic [TDW/2-1:0]         ticks = '0;
  logic [ND-1:0][CW-1:0]    sent_packets;
  logic [CW-1:0]            total_sent;
  logic                     done;

  int errors = 0;
  int checks = 0;

  axis_traffic_generator_if #(.TDATA_WIDTH(TDW), .TDEST_WIDTH(DW), .TID_WIDTH(IW)) axis ();

  axis_traffic_generator #(
    .COUNT_WIDTH(CW), .TID(1), .TDATA_WIDTH(TDW), .TDEST_WIDTH(DW),
    .TID_WIDTH(IW), .RATE_WIDTH(RW), .SEED(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rate(rate), .max_packets(max_packets),
    .ticks(ticks), .sent_packets(sent_packets), .total_sent(total_sent), .done(done),
    .axis_out(axis)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ticks = ticks + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ticks = 100;
  endtask

  // Hand-stepped LFSR from seed 1: states 0x1, 0x80200003, 0xC0300002, 0x60180001,
  // 0xB02C0003, 0xD8360002, 0x6C1B0001 give destinations 0,2,3,1,2,3,1.
  int exp_dest [7] = '{0, 2, 3, 1, 2, 3, 1};
  int exp_seqt [7] = '{0, 0, 0, 0, 1, 1, 1};

  initial begin
    int exp_seq [ND];
    int gaps, seq_bad, accepts, cnt, acc, cyc, sum;
    logic will_accept;

    axis.tready = 1'b0;
    do_reset();
    check("rst_tvalid", axis.tvalid, 1'b0);
    check("rst_tdata", axis.tdata, '0);
    check("rst_tdest", axis.tdest, '0);
    check("rst_total", total_sent, '0);
    check("rst_done", done, 1'b0);
    check("rst_sent", sent_packets, '0);
    check("tlast_const", axis.tlast, 1'b1);
    check("tid_const", axis.tid, 2'd1);

    // Full rate, always ready
    enable = 1'b1; rate = 256; axis.tready = 1'b1;
    for (int d = 0; d < ND; d++) exp_seq[d] = 0;
    gaps = 0; seq_bad = 0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (k <= 7) begin
        check("full_tdest", axis.tdest, exp_dest[k-1]);
        check("full_tdata", axis.tdata, {32'(99 + k), 32'(exp_seqt[k-1])});
        check("full_total", total_sent, k - 1);
      end
      if (axis.tvalid !== 1'b1) gaps++;
      else begin
        if (axis.tdata[CW-1:0] !== 32'(exp_seq[axis.tdest])) seq_bad++;
        exp_seq[axis.tdest]++;
      end
    end
    enable = 1'b0;
    step();
    accepts = 0; sum = 0;
    for (int d = 0; d < ND; d++) begin
      accepts += exp_seq[d];
      sum += int'(sent_packets[d]);
      check("full_sent_dest", sent_packets[d], exp_seq[d]);
      check("full_dest_spread", (exp_seq[d] >= 213 && exp_seq[d] <= 287), 1'b1);
    end
    check("full_gaps", gaps, 0);
    check("full_seq_order", seq_bad, 0);
    check("full_accepts", accepts, 1000);
    check("full_total_end", total_sent, accepts);
    check("full_sum_sent", sum, total_sent);
    check("full_idle_after", axis.tvalid, 1'b0);

    // rate 0 never injects, rate 128 injects about half the time
    do_reset();
    enable = 1'b1; rate = 0; axis.tready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 500; k++) begin
      step();
      if (axis.tvalid) cnt++;
    end
    check("rate0_valid", cnt, 0);
    check("rate0_total", total_sent, '0);
    rate = 128;
    cnt = 0;
    for (int k = 0; k < 4000; k++) begin
      step();
      if (axis.tvalid) cnt++;
    end
    check("rate128_fraction", (cnt >= 1800 && cnt <= 2200), 1'b1);

    // 20-cycle stall holds the packet, counters stay 0 until the accept
    do_reset();
    enable = 1'b1; rate = 256; axis.tready = 1'b0;
    step();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (axis.tvalid !== 1'b1 || axis.tdest !== 2'd0 || axis.tdata !== {32'd100, 32'd0}
          || total_sent !== '0) cnt++;
    end
    check("stall_hold", cnt, 0);
    axis.tready = 1'b1;
    step();
    check("stall_total1", total_sent, 1);
    check("stall_sent0", sent_packets[0], 1);
    step();
    check("stall_total2", total_sent, 2);

    // enable drop keeps the pending packet; mid-VALID reset restarts everything
    do_reset();
    enable = 1'b1; rate = 256; axis.tready = 1'b0;
    step();
    enable = 1'b0;
    step(); step(); step();
    check("en_hold_valid", axis.tvalid, 1'b1);
    check("en_hold_data", axis.tdata, {32'd100, 32'd0});
    axis.tready = 1'b1;
    step();
    check("en_one_accept", total_sent, 1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (axis.tvalid) cnt++;
    end
    check("en_no_reload", cnt, 0);
    check("en_total_stays", total_sent, 1);
    enable = 1'b1; axis.tready = 1'b0;
    step();
    check("mid_valid_up", axis.tvalid, 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_tvalid", axis.tvalid, 1'b0);
    check("mid_rst_total", total_sent, '0);
    check("mid_rst_sent", sent_packets, '0);
    rst = 1'b0; ticks = 100; axis.tready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("lfsr_repeat_tdest", axis.tdest, exp_dest[k-1]);
    end

    // Packet limit with random backpressure
    do_reset();
    enable = 1'b1; rate = 256; max_packets = 10;
    acc = 0; cyc = 0;
    while (acc < 10 && cyc < 500) begin
      axis.tready = 1'($urandom_range(0, 1));
      will_accept = axis.tvalid && axis.tready;
      step();
      cyc++;
      if (will_accept) acc++;
    end
    check("limit_accepts", acc, 10);
    check("limit_done", done, 1'b1);
    check("limit_total", total_sent, 10);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      axis.tready = 1'($urandom_range(0, 1));
      step();
      if (axis.tvalid || !done) cnt++;
    end
    check("limit_quiet", cnt, 0);
    check("limit_total_final", total_sent, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
